// File: rtl/pixel_burst_controller_if.sv
// SRAM-side bus of the pixel burst controller: address, RGB write/read data
// and the two access strobes. The controller is the master, the SRAM the slave.
interface pixel_burst_controller_if #(
  parameter int ADDR_BITS = 16,
  parameter int PIX_BITS  = 8
);
  logic [ADDR_BITS-1:0]  address;
  logic [3*PIX_BITS-1:0] w_data;
  logic [3*PIX_BITS-1:0] r_data;
  logic                  read_enable;
  logic                  write_enable;

  modport master (
    output address, w_data, read_enable, write_enable,
    input  r_data
  );

  modport slave (
    input  address, w_data, read_enable, write_enable,
    output r_data
  );
endinterface

// File: rtl/pixel_burst_controller.sv
// Pixel burst controller: moves a burst of up to MAX_PIX consecutive pixels
// between the edge-detector datapath and a 24-bit RGB SRAM. Reads reduce each
// RGB word to greyscale, writes replicate a greyscale byte to RGB. Every SRAM
// access is held for SRAM_WAIT cycles.
module pixel_burst_controller #(
  parameter int ADDR_BITS = 16,
  parameter int MAX_PIX   = 20,
  parameter int PIX_BITS  = 8,
  parameter int CNT_BITS  = 5,
  parameter int SRAM_WAIT = 5
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        op_write,
  input  logic [ADDR_BITS-1:0]        base_addr,
  input  logic [CNT_BITS-1:0]         num_pix,
  input  logic [MAX_PIX*PIX_BITS-1:0] data_in,
  output logic [MAX_PIX*PIX_BITS-1:0] data_out,
  output logic                        busy,
  output logic                        done,
  pixel_burst_controller_if.master    sram
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int WAIT_BITS = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(SRAM_WAIT - 1);
  localparam logic [CNT_BITS-1:0]  MAX_N     = CNT_BITS'(MAX_PIX);

  logic [1:0]                  state_q, state_d;
  logic [CNT_BITS-1:0]         n_q, n_d;
  logic [CNT_BITS-1:0]         idx_q, idx_d;
  logic [WAIT_BITS-1:0]        wait_q, wait_d;
  logic [ADDR_BITS-1:0]        address_q, address_d;
  logic [MAX_PIX*PIX_BITS-1:0] pix_q, pix_d;
  logic [MAX_PIX*PIX_BITS-1:0] data_out_q, data_out_d;

  logic [CNT_BITS-1:0] n_clamp;
  logic [PIX_BITS+1:0] grey_sum;
  logic [PIX_BITS-1:0] grey;
  logic [PIX_BITS-1:0] wr_pix;

  assign n_clamp = (num_pix > MAX_N) ? MAX_N : num_pix;

  // R + 2G + B fits in PIX_BITS+2 bits; dropping two LSBs divides by four.
  assign grey_sum = {2'b00, sram.r_data[3*PIX_BITS-1:2*PIX_BITS]}
                  + {1'b0, sram.r_data[2*PIX_BITS-1:PIX_BITS], 1'b0}
                  + {2'b00, sram.r_data[PIX_BITS-1:0]};
  assign grey     = grey_sum[PIX_BITS+1:2];
  assign wr_pix   = pix_q[int'(idx_q)*PIX_BITS +: PIX_BITS];

  // Next-state and datapath update for the burst FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    address_d  = address_q;
    pix_d      = pix_q;
    data_out_d = data_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = n_clamp;
          idx_d     = '0;
          wait_d    = '0;
          address_d = base_addr;
          pix_d     = data_in;
          if (n_clamp == '0)  state_d = DONE;
          else if (op_write)  state_d = WRITE;
          else                state_d = READ;
        end
      end
      READ, WRITE: begin
        if (wait_q == WAIT_LAST) begin
          if (state_q == READ) data_out_d[int'(idx_q)*PIX_BITS +: PIX_BITS] = grey;
          wait_d    = '0;
          idx_d     = idx_q + 1'b1;
          address_d = address_q + 1'b1;
          if (idx_q == n_q - 1'b1) state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      address_q  <= '0;
      // NOTE: the latched pixel copy and data_out are reset too, so every output is 0 out of reset.
      pix_q      <= '0;
      data_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      address_q  <= address_d;
      pix_q      <= pix_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy              = (state_q == READ) || (state_q == WRITE);
  assign done              = (state_q == DONE);
  assign data_out          = data_out_q;
  assign sram.address      = address_q;
  assign sram.read_enable  = (state_q == READ);
  assign sram.write_enable = (state_q == WRITE);
  assign sram.w_data       = (state_q == WRITE) ? {3{wr_pix}} : '0;

endmodule
